capture_ctrl: RTL and testbench

Acquisition controller between the AFE/ADC front end and the three RAM512 sample buffers of the DSO. It generates the ADC sample clock, writes decimated samples into the 512-entry circular buffers, qualifies trigger edges from the AFE comparators, and stops after a programmed number of post-trigger samples. It hands the RAM address port over to the host-side read path once capture completes.

---
 rtl/capture_ctrl.sv | 150 +++++++++++++++
 tb/tb_capture_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// DSO acquisition controller: ADC sample clock, decimated circular writes into the
// RAM512 buffers, trigger qualification, post-trigger countdown and host read hand-over.
module capture_ctrl #(
   parameter int DEPTH = 512,
   parameter int AW    = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          capture_start,
   input  logic [1:0]    trig_sel,
   input  logic          trig_edge,
   input  logic [AW-1:0] trig_pos,
   input  logic [3:0]    decimator,
   input  logic          trig1,
   input  logic          trig2,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic          adc_clk,
   output logic          en,
   output logic          we,
   output logic [AW-1:0] addr,
   output logic          capture_done,
   output logic [AW-1:0] start_addr,
   output logic          busy
);

   typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic          adc_clk_q, adc_clk_d;
   logic [15:0]   dec_q, dec_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW:0]   fill_q, fill_d;
   logic [AW:0]   post_q, post_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] start_addr_q, start_addr_d;
   logic [1:0]    sync1_q, sync2_q, hist_q;

   logic          slot, active_q, active_d;
   logic          cur, prev, edge_sel, trig_event;
   logic [15:0]   dec_mask;
   logic [AW:0]   pre_need;

   assign slot     = ~adc_clk_q;
   assign active_q = (state_q == FILL) || (state_q == ARMED) || (state_q == POST);
   assign dec_mask = (16'd1 << decimator) - 16'd1;
   assign pre_need = DEPTH_W - {1'b0, trig_pos};

   // Edge detection on the synchronised, history-delayed copy of the selected pin
   always_comb begin
      cur        = trig_sel[0] ? sync2_q[1] : sync2_q[0];
      prev       = trig_sel[0] ? hist_q[1]  : hist_q[0];
      edge_sel   = trig_edge ? (~prev & cur) : (prev & ~cur);
      trig_event = (trig_sel == 2'b10) || (~trig_sel[1] && edge_sel);
   end

   always_comb begin
      adc_clk_d = ~adc_clk_q;
      dec_d     = dec_q;
      wptr_d    = wptr_q;
      fill_d    = fill_q;
      post_d    = post_q;
      if (slot && active_q) dec_d = dec_q + 16'd1;
      if (we_q) begin
         wptr_d = wptr_q + 1'b1;
         if (fill_q != DEPTH_W) fill_d = fill_q + 1'b1;
         if (state_q == POST)   post_d = post_q + 1'b1;
      end
      if (capture_start) begin
         dec_d  = '0;
         wptr_d = '0;
         fill_d = '0;
         post_d = '0;
      end
   end

   // Transitions use the counts including this cycle's write, so the write that
   // completes a phase is the last one of that phase.
   always_comb begin
      state_d = state_q;
      if (capture_start) begin
         state_d = FILL;
      end else begin
         case (state_q)
            FILL:    if (fill_d >= pre_need) state_d = ARMED;
            ARMED:   if (trig_event) state_d = (trig_pos == '0) ? DONE : POST;
            POST:    if (we_q && (post_d == {1'b0, trig_pos})) state_d = DONE;
            default: state_d = state_q;
         endcase
      end
   end

   // Outputs are precomputed one cycle ahead so they leave the block registered
   always_comb begin
      active_d     = (state_d == FILL) || (state_d == ARMED) || (state_d == POST);
      we_d         = active_d && ~adc_clk_d && ((dec_d & dec_mask) == 16'd0);
      addr_d       = wptr_d;
      busy_d       = active_d;
      done_d       = (state_d == DONE);
      start_addr_d = done_d ? wptr_d : start_addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         adc_clk_q    <= 1'b0;
         dec_q        <= '0;
         wptr_q       <= '0;
         fill_q       <= '0;
         post_q       <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         start_addr_q <= '0;
         sync1_q      <= '0;
         sync2_q      <= '0;
         hist_q       <= '0;
      end else begin
         state_q      <= state_d;
         adc_clk_q    <= adc_clk_d;
         dec_q        <= dec_d;
         wptr_q       <= wptr_d;
         fill_q       <= fill_d;
         post_q       <= post_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         start_addr_q <= start_addr_d;
         sync1_q      <= {trig2, trig1};
         sync2_q      <= sync1_q;
         hist_q       <= sync2_q;
      end
   end

   assign adc_clk      = adc_clk_q;
   assign we           = we_q;
   assign en           = done_q ? rd_en : we_q;
   assign addr         = done_q ? rd_addr : addr_q;
   assign capture_done = done_q;
   assign start_addr   = start_addr_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: reset, force/edge triggers, decimation, restart
// and host read-back, with a write monitor folded into the clock-step task.
module tb_capture_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       capture_start;
   logic [1:0] trig_sel;
   logic       trig_edge;
   logic [8:0] trig_pos;
   logic [3:0] decimator;
   logic       trig1, trig2;
   logic       rd_en;
   logic [8:0] rd_addr;
   logic       adc_clk, en, we, capture_done, busy;
   logic [8:0] addr, start_addr;

   capture_ctrl #(.DEPTH(512), .AW(9)) dut (
      .clk(clk), .rst(rst), .capture_start(capture_start), .trig_sel(trig_sel),
      .trig_edge(trig_edge), .trig_pos(trig_pos), .decimator(decimator),
      .trig1(trig1), .trig2(trig2), .rd_en(rd_en), .rd_addr(rd_addr),
      .adc_clk(adc_clk), .en(en), .we(we), .addr(addr),
      .capture_done(capture_done), .start_addr(start_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int start_cyc = 0;
   int wcnt [512];
   int nwr, last_wr, seq_err, gap_err, gap_exp, post_from, npost;
   logic [8:0] last_addr, first_addr;
   bit wrapped;

   task automatic clr_mon();
      for (int a = 0; a < 512; a++) wcnt[a] = 0;
      nwr = 0; last_wr = 0; seq_err = 0; gap_err = 0; npost = 0;
      post_from = 32'h7fff_ffff; last_addr = '0; first_addr = '0; wrapped = 0;
   endtask

   // One clock step; samples the write port of the new cycle away from the edge
   task automatic tick();
      @(posedge clk);
      #2;
      cyc++;
      if (we === 1'b1) begin
         wcnt[addr]++;
         if (nwr == 0) first_addr = addr;
         if (nwr > 0 && addr != last_addr + 9'd1) seq_err++;
         if (nwr > 0 && gap_exp != 0 && (cyc - last_wr) != gap_exp) gap_err++;
         if (nwr > 0 && last_addr == 9'd511 && addr == 9'd0) wrapped = 1;
         if (cyc >= post_from) npost++;
         last_wr = cyc;
         last_addr = addr;
         nwr++;
      end
   endtask

   task automatic pulse_start();
      capture_start = 1'b1;
      start_cyc = cyc;
      tick();
      capture_start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      for (int i = 0; i < bound && capture_done !== 1'b1; i++) tick();
      ok = (capture_done === 1'b1);
   endtask

   task automatic test_reset();
      int nw;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++;
         if (adc_clk !== 1'b0) begin n_err++; $display("FAIL reset_adc_clk: got %b want 0", adc_clk); end
      end
      n_vec++;
      if ({adc_clk, en, we, addr, capture_done, start_addr, busy} !== 23'd0) begin
         n_err++; $display("FAIL reset_outputs: got %h want 0", {adc_clk, en, we, addr, capture_done, start_addr, busy});
      end
      rst = 1'b0;
      tick();
      n_vec++;
      if (adc_clk !== 1'b1) begin n_err++; $display("FAIL adc_clk_toggle1: got %b want 1", adc_clk); end
      tick();
      n_vec++;
      if (adc_clk !== 1'b0) begin n_err++; $display("FAIL adc_clk_toggle0: got %b want 0", adc_clk); end
      rd_en = 1'b1; rd_addr = 9'd5;
      #1;
      n_vec++;
      if ({en, addr} !== 10'd0) begin n_err++; $display("FAIL idle_read_ignored: got en=%b addr=%0d want en=0 addr=0", en, addr); end
      rd_en = 1'b0; rd_addr = '0;
      // Reset in the middle of a capture
      trig_sel = 2'b11; gap_exp = 2;
      clr_mon();
      pulse_start();
      repeat (50) tick();
      n_vec++;
      if (busy !== 1'b1 || nwr < 20) begin n_err++; $display("FAIL midcap_running: got busy=%b writes=%0d want busy=1 writes>=20", busy, nwr); end
      rst = 1'b1;
      tick();
      n_vec++;
      if (adc_clk !== 1'b0) begin n_err++; $display("FAIL midcap_adc_held1: got %b want 0", adc_clk); end
      tick();
      n_vec++;
      if ({adc_clk, en, we, addr, capture_done, start_addr, busy} !== 23'd0) begin
         n_err++; $display("FAIL midcap_reset_outputs: got %h want 0", {adc_clk, en, we, addr, capture_done, start_addr, busy});
      end
      rst = 1'b0;
      clr_mon();
      tick();
      n_vec++;
      if (adc_clk !== 1'b1) begin n_err++; $display("FAIL midcap_adc_resume: got %b want 1", adc_clk); end
      repeat (10) tick();
      nw = nwr;
      n_vec++;
      if (nw != 0 || busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got writes=%0d busy=%b want 0 0", nw, busy); end
   endtask

   task automatic test_force();
      bit ok;
      int bad;
      trig_sel = 2'b10; trig_pos = 9'd100; decimator = 4'd0; gap_exp = 2;
      clr_mon();
      pulse_start();
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL force_busy: got %b want 1", busy); end
      wait_done(1200, ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL force_timeout: got done=%b want 1", capture_done);
      end else begin
         n_vec++;
         if ((cyc - start_cyc) < 1022 || (cyc - start_cyc) > 1026) begin
            n_err++; $display("FAIL force_latency: got %0d want 1024+-2", cyc - start_cyc);
         end
         n_vec++;
         if (nwr != 512) begin n_err++; $display("FAIL force_writes: got %0d want 512", nwr); end
         bad = 0;
         for (int a = 0; a < 512; a++) if (wcnt[a] != 1) bad++;
         n_vec++;
         if (bad != 0) begin n_err++; $display("FAIL force_addr_once: got %0d bad addresses want 0", bad); end
         n_vec++;
         if (seq_err != 0 || gap_err != 0) begin n_err++; $display("FAIL force_cadence: got seq=%0d gap=%0d want 0 0", seq_err, gap_err); end
         n_vec++;
         if (start_addr !== 9'd0) begin n_err++; $display("FAIL force_start_addr: got %0d want 0", start_addr); end
         n_vec++;
         if (cyc != last_wr + 1 || busy !== 1'b0 || we !== 1'b0) begin
            n_err++; $display("FAIL force_done_timing: got done_cyc=%0d last_wr=%0d busy=%b we=%b want last_wr+1 0 0", cyc, last_wr, busy, we);
         end
      end
   endtask

   task automatic test_rising();
      bit ok;
      trig_sel = 2'b00; trig_edge = 1'b1; trig_pos = 9'd256; decimator = 4'd0; gap_exp = 2;
      trig1 = 1'b0; trig2 = 1'b0;
      clr_mon();
      pulse_start();
      repeat (100) tick();
      trig1 = 1'b1;
      repeat (4) tick();
      trig1 = 1'b0;
      repeat (600) tick();
      n_vec++;
      if (capture_done !== 1'b0 || busy !== 1'b1) begin
         n_err++; $display("FAIL rise_fill_ignored: got done=%b busy=%b want 0 1", capture_done, busy);
      end
      trig1 = 1'b1;
      post_from = cyc + 3;
      wait_done(700, ok);
      trig1 = 1'b0;
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL rise_timeout: got done=%b want 1", capture_done);
      end else begin
         n_vec++;
         if (npost != 256) begin n_err++; $display("FAIL rise_post_writes: got %0d want 256", npost); end
         n_vec++;
         if (start_addr !== 9'(nwr % 512)) begin n_err++; $display("FAIL rise_start_addr: got %0d want %0d", start_addr, nwr % 512); end
         n_vec++;
         if (cyc != last_wr + 1 || seq_err != 0 || gap_err != 0) begin
            n_err++; $display("FAIL rise_done_timing: got done_cyc=%0d last_wr=%0d seq=%0d gap=%0d", cyc, last_wr, seq_err, gap_err);
         end
      end
   endtask

   task automatic test_falling();
      int e;
      trig_sel = 2'b01; trig_edge = 1'b0; trig_pos = 9'd0; decimator = 4'd0; gap_exp = 2;
      trig1 = 1'b0; trig2 = 1'b0;
      clr_mon();
      pulse_start();
      repeat (1100) tick();
      n_vec++;
      if (capture_done !== 1'b0) begin n_err++; $display("FAIL fall_armed_wait: got done=%b want 0", capture_done); end
      trig2 = 1'b1;
      repeat (10) tick();
      n_vec++;
      if (capture_done !== 1'b0) begin n_err++; $display("FAIL fall_rising_ignored: got done=%b want 0", capture_done); end
      trig2 = 1'b0;
      e = cyc;
      post_from = e + 3;
      tick(); tick();
      n_vec++;
      if (capture_done !== 1'b0) begin n_err++; $display("FAIL fall_detect_cycle: got done=%b want 0", capture_done); end
      tick();
      n_vec++;
      if (capture_done !== 1'b1 || busy !== 1'b0) begin
         n_err++; $display("FAIL fall_done_next: got done=%b busy=%b want 1 0", capture_done, busy);
      end
      repeat (6) tick();
      n_vec++;
      if (npost != 0 || nwr < 512) begin n_err++; $display("FAIL fall_no_extra: got post=%0d total=%0d want 0 >=512", npost, nwr); end
      n_vec++;
      if (start_addr !== 9'(nwr % 512)) begin n_err++; $display("FAIL fall_start_addr: got %0d want %0d", start_addr, nwr % 512); end
   endtask

   task automatic test_decim();
      trig_sel = 2'b11; trig_pos = 9'd0; decimator = 4'd3; gap_exp = 16;
      clr_mon();
      pulse_start();
      repeat (8400) tick();
      n_vec++;
      if (gap_err != 0 || seq_err != 0) begin n_err++; $display("FAIL decim_gap: got gap=%0d seq=%0d want 0 0", gap_err, seq_err); end
      n_vec++;
      if (nwr < 525 || nwr > 526) begin n_err++; $display("FAIL decim_count: got %0d want 525..526", nwr); end
      n_vec++;
      if (!wrapped) begin n_err++; $display("FAIL decim_wrap: got %0d want 1", wrapped); end
      n_vec++;
      if (capture_done !== 1'b0 || busy !== 1'b1) begin
         n_err++; $display("FAIL decim_never_done: got done=%b busy=%b want 0 1", capture_done, busy);
      end
   endtask

   task automatic test_restart_read();
      bit ok;
      int bad;
      trig_sel = 2'b10; trig_pos = 9'd200; decimator = 4'd0; gap_exp = 2;
      clr_mon();
      pulse_start();
      repeat (800) tick();
      n_vec++;
      if (busy !== 1'b1 || capture_done !== 1'b0) begin
         n_err++; $display("FAIL restart_in_post: got busy=%b done=%b want 1 0", busy, capture_done);
      end
      clr_mon();
      pulse_start();
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL restart_busy: got %b want 1", busy); end
      wait_done(1200, ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL restart_timeout: got done=%b want 1", capture_done);
      end else begin
         n_vec++;
         if (nwr != 512 || first_addr !== 9'd0) begin
            n_err++; $display("FAIL restart_writes: got total=%0d first=%0d want 512 0", nwr, first_addr);
         end
         bad = 0;
         for (int a = 0; a < 512; a++) if (wcnt[a] != 1) bad++;
         n_vec++;
         if (bad != 0) begin n_err++; $display("FAIL restart_addr_once: got %0d bad want 0", bad); end
         n_vec++;
         if ((cyc - start_cyc) < 1022 || (cyc - start_cyc) > 1026 || start_addr !== 9'd0) begin
            n_err++; $display("FAIL restart_latency: got lat=%0d start_addr=%0d want 1024+-2 0", cyc - start_cyc, start_addr);
         end
         rd_en = 1'b1; rd_addr = 9'd37;
         #1;
         n_vec++;
         if (en !== 1'b1 || addr !== 9'd37 || we !== 1'b0) begin
            n_err++; $display("FAIL read_37: got en=%b addr=%0d we=%b want 1 37 0", en, addr, we);
         end
         rd_addr = 9'd400;
         #1;
         n_vec++;
         if (addr !== 9'd400) begin n_err++; $display("FAIL read_400: got %0d want 400", addr); end
         rd_en = 1'b0;
         #1;
         n_vec++;
         if (en !== 1'b0 || capture_done !== 1'b1) begin
            n_err++; $display("FAIL read_release: got en=%b done=%b want 0 1", en, capture_done);
         end
      end
   endtask

   initial begin
      rst = 1'b1; capture_start = 1'b0; trig_sel = 2'b11; trig_edge = 1'b1;
      trig_pos = '0; decimator = '0; trig1 = 1'b0; trig2 = 1'b0;
      rd_en = 1'b0; rd_addr = '0; gap_exp = 0;
      clr_mon();
      test_reset();
      test_force();
      test_rising();
      test_falling();
      test_decim();
      test_restart_read();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
